// File: rtl/duty_adjust_ctrl_if.sv
// duty_adjust_ctrl_if: control/data bundle between the SWIPT parent and the duty adjuster
//   data_start/data_trans/data_rec : mode and phase controls
//   l_rdy/l_up_down               : tuning step strobe and direction
//   d                             : bit being transmitted
//   l/l_def                       : current (looped back) and frozen default lengths
//   l_adj                         : registered next length
interface duty_adjust_ctrl_if #(parameter int W = 12);
  logic data_start;
  logic data_trans;
  logic data_rec;
  logic l_rdy;
  logic l_up_down;
  logic d;
  logic [W-1:0] l;
  logic [W-1:0] l_def;
  logic [W-1:0] l_adj;
  modport master (output data_start, data_trans, data_rec, l_rdy, l_up_down, d, l, l_def, input l_adj);
  modport slave (input data_start, data_trans, data_rec, l_rdy, l_up_down, d, l, l_def, output l_adj);
endinterface

// File: rtl/duty_adjust_ctrl.sv
// duty_adjust_ctrl: registered pulse-length word, 10% tuning steps or ASK modulation around l_def
//   clk  : rising-edge clock
//   nrst : synchronous active-high reset, loads L_RESET
//   bus  : slave side of duty_adjust_ctrl_if (controls, l, l_def in; l_adj out)
module duty_adjust_ctrl #(
  parameter int W = 12,
  parameter logic [W-1:0] L_RESET = 12'h0FA,
  parameter logic [W-1:0] L_MAX = 12'h1F4,
  parameter logic [W-1:0] L_MIN = 12'h032,
  parameter int STEP_DIV = 10,
  parameter int MOD_SHIFT = 1
) (
  input logic clk,
  input logic nrst,
  duty_adjust_ctrl_if.slave bus
);
  typedef enum logic {TUNE, DATA} state_t;
  state_t state_q, state_d;
  logic [W-1:0] l_adj_q, l_nxt, step_raw, step, up_val, dn_val, tune_val, data_val;
  logic [W:0] sum, diff;
  logic rise, fall;
  always_comb begin
    rise = (state_q == TUNE) && bus.data_start;
    fall = (state_q == DATA) && !bus.data_start;
    state_d = rise ? DATA : fall ? TUNE : state_q;
    step_raw = bus.l / W'(STEP_DIV);
    step = (step_raw == '0) ? W'(1) : step_raw;
    // one extra bit so the sum cannot wrap and the difference exposes underflow
    sum = {1'b0, bus.l} + {1'b0, step};
    diff = {1'b0, bus.l} - {1'b0, step};
    up_val = (sum > {1'b0, L_MAX}) ? L_MAX : sum[W-1:0];
    dn_val = (diff[W] || diff[W-1:0] < L_MIN) ? L_MIN : diff[W-1:0];
    tune_val = bus.l_rdy ? (bus.l_up_down ? up_val : dn_val) : bus.l;
    data_val = (bus.data_trans && !bus.d) ? bus.l_def - (bus.l_def >> MOD_SHIFT) : bus.l_def;
    // decide on the incoming state so the first data cycle already uses l_def
    // and a step arriving with the fall of data_start is applied to l
    l_nxt = (state_d == DATA) ? data_val : tune_val;
  end
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q <= TUNE;
      l_adj_q <= L_RESET;
    end else begin
      state_q <= state_d;
      l_adj_q <= l_nxt;
    end
  end
  assign bus.l_adj = l_adj_q;
endmodule

// File: tb/tb_duty_adjust_ctrl.sv
// tb_duty_adjust_ctrl: directed and randomized checks of duty_adjust_ctrl against an arithmetic model
module tb_duty_adjust_ctrl;
  logic clk = 0;
  logic nrst;
  int checks = 0;
  int failures = 0;
  int model_l;
  duty_adjust_ctrl_if #(.W(12)) bus();
  duty_adjust_ctrl dut (.clk(clk), .nrst(nrst), .bus(bus));
  always #5 clk = ~clk;
  function automatic int ref_next(int rst, int ds, int dt, int rdy, int ud, int dd, int l, int ldef);
    int s;
    if (rst != 0) return 250;
    if (ds != 0) return (dt != 0 && dd == 0) ? ldef - ldef / 2 : ldef;
    if (rdy == 0) return l;
    s = l / 10;
    if (s == 0) s = 1;
    if (ud != 0) return (l + s > 500) ? 500 : l + s;
    return (l - s < 50) ? 50 : l - s;
  endfunction
  task automatic chk(string tag, int exp);
    checks++;
    assert (bus.l_adj === 12'(exp)) else begin
      failures++;
      $error("FAIL %s: l_adj=%0d expected=%0d", tag, bus.l_adj, exp);
    end
  endtask
  task automatic cyc(string tag, int rst, int ds, int dt, int dr, int rdy, int ud, int dd, int l, int ldef);
    nrst = rst[0];
    bus.data_start = ds[0];
    bus.data_trans = dt[0];
    bus.data_rec = dr[0];
    bus.l_rdy = rdy[0];
    bus.l_up_down = ud[0];
    bus.d = dd[0];
    bus.l = 12'(l);
    bus.l_def = 12'(ldef);
    model_l = ref_next(rst, ds, dt, rdy, ud, dd, l, ldef);
    @(posedge clk);
    #1;
    chk(tag, model_l);
  endtask
  initial begin
    #1;
    cyc("rst0", 1, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 4096, $urandom % 4096);
    cyc("rst1", 1, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 4096, $urandom % 4096);
    chk("reset_val", 250);
    cyc("hold", 0, 0, 0, 0, 0, 0, 0, 250, 0);
    chk("hold_250", 250);
    cyc("up250", 0, 0, 1, 1, 1, 1, 0, 250, 0);
    chk("up250_275", 275);
    cyc("dn275", 0, 0, 0, 0, 1, 0, 0, 275, 0);
    chk("dn275_248", 248);
    cyc("up480", 0, 0, 0, 0, 1, 1, 0, 480, 0);
    chk("clamp_hi", 500);
    cyc("up500", 0, 0, 0, 0, 1, 1, 0, 500, 0);
    chk("stay_hi", 500);
    cyc("dn52", 0, 0, 0, 0, 1, 0, 0, 52, 0);
    chk("clamp_lo", 50);
    cyc("up5", 0, 0, 0, 0, 1, 1, 0, 5, 0);
    chk("min_step", 6);
    cyc("dn0", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("underflow", 50);
    cyc("tx_d1", 0, 1, 1, 0, 0, 0, 1, 6, 400);
    chk("tx_d1_400", 400);
    cyc("tx_d0", 0, 1, 1, 0, 0, 0, 0, 400, 400);
    chk("tx_d0_200", 200);
    cyc("tx_rdy", 0, 1, 1, 0, 1, 1, 1, 200, 400);
    chk("tx_rdy_ignored", 400);
    cyc("tx_pri", 0, 1, 1, 1, 0, 0, 0, 400, 400);
    chk("tx_priority", 200);
    cyc("rx0", 0, 1, 0, 1, 0, 0, 0, 200, 300);
    for (int i = 0; i < 4; i++) begin
      cyc("rx", 0, 1, 0, 1, $urandom % 2, $urandom % 2, $urandom % 2, 300, 300);
      chk("rx_steady", 300);
    end
    cyc("fall_up", 0, 0, 0, 0, 1, 1, 0, 300, 300);
    chk("fall_up_330", 330);
    cyc("tx_mid", 0, 1, 1, 0, 0, 0, 0, 330, 400);
    chk("tx_mid_200", 200);
    cyc("rst_mid", 1, 1, 1, 0, 0, 0, 0, 200, 400);
    chk("rst_mid_250", 250);
    for (int i = 0; i < 300; i++) begin
      int l_in;
      l_in = ($urandom % 4 == 0) ? int'($urandom % 4096) : model_l;
      cyc("rand", ($urandom % 25 == 0) ? 1 : 0, ($urandom % 3 == 0) ? 1 : 0, $urandom % 2, $urandom % 2,
          $urandom % 2, $urandom % 2, $urandom % 2, l_in, $urandom % 4096);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
